// File: rtl/local_hist_table_pkg.sv
// Shared types for the local branch history table: history word, FSM states, shift helper.
// hist_t is sized by LHT_HIST_WIDTH; the table's HIST_WIDTH parameter must track it.
package lht_pkg;

    localparam int LHT_HIST_WIDTH  = 8;
    localparam int LHT_INDEX_WIDTH = 6;

    typedef logic [LHT_HIST_WIDTH-1:0] hist_t;

    typedef enum logic {
        LHT_IDLE = 1'b0,
        LHT_HOLD = 1'b1
    } lht_state_e;

    // Newest outcome enters at the LSB; the oldest bit falls off the MSB.
    function automatic hist_t shift_in(hist_t old, logic outcome);
        return {old[LHT_HIST_WIDTH-2:0], outcome};
    endfunction

endpackage

// File: rtl/lht_spec_array.sv
// Speculative history storage: two shift ports with same-entry merge, bulk load, two raw read ports.
module lht_spec_array
    import lht_pkg::*;
#(
    parameter int HIST_WIDTH  = LHT_HIST_WIDTH,
    parameter int INDEX_WIDTH = LHT_INDEX_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   en0,
    input  logic                   taken0,
    input  logic [INDEX_WIDTH-1:0] idx0,
    input  logic                   en1,
    input  logic                   taken1,
    input  logic [INDEX_WIDTH-1:0] idx1,
    input  logic                   load,
    input  hist_t                  load_data [2**INDEX_WIDTH],
    input  logic [INDEX_WIDTH-1:0] rd_idx0,
    input  logic [INDEX_WIDTH-1:0] rd_idx1,
    output logic [HIST_WIDTH-1:0]  rd_hist0,
    output logic [HIST_WIDTH-1:0]  rd_hist1
);

    localparam int DEPTH = 2**INDEX_WIDTH;

    hist_t spec_q [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) spec_q[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < DEPTH; i++) spec_q[i] <= load_data[i];
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                // Same-entry pair: slot 0 is the older branch, so it shifts in first.
                if (en0 && idx0 == INDEX_WIDTH'(i) && en1 && idx1 == INDEX_WIDTH'(i))
                    spec_q[i] <= shift_in(shift_in(spec_q[i], taken0), taken1);
                else if (en0 && idx0 == INDEX_WIDTH'(i))
                    spec_q[i] <= shift_in(spec_q[i], taken0);
                else if (en1 && idx1 == INDEX_WIDTH'(i))
                    spec_q[i] <= shift_in(spec_q[i], taken1);
            end
        end
    end

    assign rd_hist0 = spec_q[rd_idx0];
    assign rd_hist1 = spec_q[rd_idx1];

endmodule

// File: rtl/local_hist_table.sv
// Local branch history table with speculative/committed copies and flush recovery.
// Optional macro LHT_INTRA_BUNDLE_FWD_EN forwards slot 0's prediction to slot 1's read.
module local_hist_table
    import lht_pkg::*;
#(
    parameter int HIST_WIDTH  = LHT_HIST_WIDTH,
    parameter int INDEX_WIDTH = LHT_INDEX_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [INDEX_WIDTH-1:0] rd_idx0,
    input  logic [INDEX_WIDTH-1:0] rd_idx1,
    output logic [HIST_WIDTH-1:0]  rd_hist0,
    output logic [HIST_WIDTH-1:0]  rd_hist1,
    input  logic                   spec_en0,
    input  logic                   spec_taken0,
    input  logic [INDEX_WIDTH-1:0] spec_idx0,
    input  logic                   spec_en1,
    input  logic                   spec_taken1,
    input  logic [INDEX_WIDTH-1:0] spec_idx1,
    input  logic                   cmt_en,
    input  logic                   cmt_taken,
    input  logic [INDEX_WIDTH-1:0] cmt_idx,
    input  logic                   flush,
    output logic                   busy
);

    // state    | meaning
    // LHT_IDLE | normal operation, speculative updates accepted
    // LHT_HOLD | one cycle after a flush copy; speculative updates dropped
    localparam int DEPTH = 2**INDEX_WIDTH;

    lht_state_e state_q;
    hist_t      arch_q    [DEPTH];
    hist_t      arch_next [DEPTH];
    logic       hold;
    logic       spec_block;
    logic [HIST_WIDTH-1:0] arr_hist1;

    assign hold       = (state_q == LHT_HOLD);
    assign spec_block = flush || hold;
    assign busy       = hold;

    // The post-commit value feeds both the ARCH register and the flush copy.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) arch_next[i] = arch_q[i];
        if (cmt_en) arch_next[cmt_idx] = shift_in(arch_q[cmt_idx], cmt_taken);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= LHT_IDLE;
            for (int i = 0; i < DEPTH; i++) arch_q[i] <= '0;
        end else begin
            state_q <= flush ? LHT_HOLD : LHT_IDLE;
            for (int i = 0; i < DEPTH; i++) arch_q[i] <= arch_next[i];
        end
    end

    lht_spec_array #(
        .HIST_WIDTH  (HIST_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_spec (
        .clock     (clock),
        .reset     (reset),
        .en0       (spec_en0 && !spec_block),
        .taken0    (spec_taken0),
        .idx0      (spec_idx0),
        .en1       (spec_en1 && !spec_block),
        .taken1    (spec_taken1),
        .idx1      (spec_idx1),
        .load      (flush),
        .load_data (arch_next),
        .rd_idx0   (rd_idx0),
        .rd_idx1   (rd_idx1),
        .rd_hist0  (rd_hist0),
        .rd_hist1  (arr_hist1)
    );

`ifdef LHT_INTRA_BUNDLE_FWD_EN
    logic fwd1;
    assign fwd1     = spec_en0 && (spec_idx0 == rd_idx1) && !spec_block;
    assign rd_hist1 = fwd1 ? shift_in(arr_hist1, spec_taken0) : arr_hist1;
`else
    assign rd_hist1 = arr_hist1;
`endif

endmodule

// File: tb/tb_local_hist_table.sv
// Randomised and directed check of local_hist_table against an array-based reference model.
module tb_local_hist_table;

    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] rd_idx0, rd_idx1, spec_idx0, spec_idx1, cmt_idx;
    logic [7:0] rd_hist0, rd_hist1;
    logic       spec_en0, spec_taken0, spec_en1, spec_taken1;
    logic       cmt_en, cmt_taken, flush, busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] sm [64];
    logic [7:0] am [64];
    bit         hm;
    bit         valid = 1'b0;

    local_hist_table dut (
        .clock(clock), .reset(reset),
        .rd_idx0(rd_idx0), .rd_idx1(rd_idx1),
        .rd_hist0(rd_hist0), .rd_hist1(rd_hist1),
        .spec_en0(spec_en0), .spec_taken0(spec_taken0), .spec_idx0(spec_idx0),
        .spec_en1(spec_en1), .spec_taken1(spec_taken1), .spec_idx1(spec_idx1),
        .cmt_en(cmt_en), .cmt_taken(cmt_taken), .cmt_idx(cmt_idx),
        .flush(flush), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] nx(logic [7:0] old, logic b);
        int v;
        v = (int'(old) * 2 + int'(b)) % 256;
        return 8'(v);
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        reset = 0; flush = 0; cmt_en = 0; cmt_taken = 0; cmt_idx = 0;
        spec_en0 = 0; spec_taken0 = 0; spec_idx0 = 0;
        spec_en1 = 0; spec_taken1 = 0; spec_idx1 = 0;
        rd_idx0 = 0; rd_idx1 = 0;
    endtask

    // Check the combinational outputs against the model, away from the clock edge.
    task automatic sample();
        logic [7:0] e1;
        #1;
        if (valid) begin
            e1 = sm[rd_idx1];
`ifdef LHT_INTRA_BUNDLE_FWD_EN
            if (spec_en0 && spec_idx0 == rd_idx1 && !flush && !hm) e1 = nx(sm[rd_idx1], spec_taken0);
`endif
            chk("model_rd0", rd_hist0, sm[rd_idx0]);
            chk("model_rd1", rd_hist1, e1);
            chk("model_busy", {7'b0, busy}, {7'b0, hm});
        end
    endtask

    task automatic advance();
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < 64; i++) begin sm[i] = 0; am[i] = 0; end
            hm = 0;
            valid = 1;
        end else if (valid) begin
            if (cmt_en) am[cmt_idx] = nx(am[cmt_idx], cmt_taken);
            if (flush) begin
                for (int i = 0; i < 64; i++) sm[i] = am[i];
                hm = 1;
            end else begin
                if (!hm) begin
                    if (spec_en0 && spec_en1 && spec_idx0 == spec_idx1)
                        sm[spec_idx0] = nx(nx(sm[spec_idx0], spec_taken0), spec_taken1);
                    else begin
                        if (spec_en0) sm[spec_idx0] = nx(sm[spec_idx0], spec_taken0);
                        if (spec_en1) sm[spec_idx1] = nx(sm[spec_idx1], spec_taken1);
                    end
                end
                hm = 0;
            end
        end
        @(negedge clock);
    endtask

    task automatic tick();
        sample();
        advance();
    endtask

    initial begin
        idle();
        reset = 1; tick(); tick();

        idle(); rd_idx0 = 3; rd_idx1 = 5;
        sample();
        chk("reset_rd0", rd_hist0, 8'h00);
        chk("reset_rd1", rd_hist1, 8'h00);
        chk("reset_busy", {7'b0, busy}, 8'h00);
        advance();

        idle(); spec_en0 = 1; spec_idx0 = 3; spec_taken0 = 1; tick();
        spec_taken0 = 0; tick();
        idle(); rd_idx0 = 3;
        sample(); chk("spec_idx3", rd_hist0, 8'h02); advance();

        idle(); spec_en0 = 1; spec_idx0 = 7;
        spec_taken0 = 1; tick();
        spec_taken0 = 0; tick();
        spec_taken0 = 1; tick();
        idle(); rd_idx0 = 7;
        sample(); chk("pre_merge_idx7", rd_hist0, 8'h05); advance();
        idle(); spec_en0 = 1; spec_en1 = 1; spec_idx0 = 7; spec_idx1 = 7;
        spec_taken0 = 1; spec_taken1 = 1; tick();
        idle(); rd_idx0 = 7;
        sample(); chk("merge_idx7", rd_hist0, 8'h17); advance();

        idle(); cmt_en = 1; cmt_idx = 3; cmt_taken = 1; flush = 1; tick();
        idle(); rd_idx0 = 3; spec_en0 = 1; spec_idx0 = 3; spec_taken0 = 1;
        sample();
        chk("flush_idx3", rd_hist0, 8'h01);
        chk("hold_busy", {7'b0, busy}, 8'h01);
        advance();
        idle(); rd_idx0 = 3;
        sample();
        chk("hold_ignored", rd_hist0, 8'h01);
        chk("hold_done", {7'b0, busy}, 8'h00);
        advance();

        idle(); spec_en0 = 1; spec_idx0 = 9; spec_taken0 = 1; tick();
        rd_idx1 = 9;
        sample();
`ifdef LHT_INTRA_BUNDLE_FWD_EN
        chk("fwd_rd1", rd_hist1, 8'h03);
`else
        chk("nofwd_rd1", rd_hist1, 8'h01);
`endif
        advance();

        idle(); flush = 1; tick();
        idle(); reset = 1;
        sample(); chk("hold_before_rst", {7'b0, busy}, 8'h01); advance();
        idle(); rd_idx0 = 3; rd_idx1 = 7;
        sample();
        chk("rst_hold_rd0", rd_hist0, 8'h00);
        chk("rst_hold_rd1", rd_hist1, 8'h00);
        chk("rst_hold_busy", {7'b0, busy}, 8'h00);
        advance();

        // Populate a handful of entries, then mix everything.
        for (int n = 0; n < 500; n++) begin
            reset       = ($urandom_range(0, 99) == 0);
            flush       = ($urandom_range(0, 11) == 0);
            cmt_en      = $urandom_range(0, 1);
            cmt_taken   = $urandom_range(0, 1);
            cmt_idx     = 6'($urandom_range(0, 7));
            spec_en0    = ($urandom_range(0, 3) != 0);
            spec_taken0 = $urandom_range(0, 1);
            spec_idx0   = 6'($urandom_range(0, 7));
            spec_en1    = ($urandom_range(0, 3) != 0);
            spec_taken1 = $urandom_range(0, 1);
            spec_idx1   = 6'($urandom_range(0, 7));
            rd_idx0     = 6'($urandom_range(0, 7));
            rd_idx1     = ($urandom_range(0, 1) == 0) ? spec_idx0 : 6'($urandom_range(0, 7));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
